register_restore: RTL and testbench
===================================

// Module: register_restore
// PURPOSE
// - Rollback engine for speculative execution: on a branch mispredict, writes the held register snapshot back into the register file.
// - Sits between hazard control and the register file write port, alongside the snapshot unit.
// - Tracks which registers were written since the last snapshot (dirty mask) and restores only those, one per cycle.
// - Stalls the pipeline via busy until the restore completes.
// PARAMETERS
// - DATA_WIDTH  32  register width
// - NUM_REGS    32  architectural registers; index width AW = $clog2(NUM_REGS)
// PORTS
// - clk             in   1                     clock, rising edge
// - rst_n           in   1                     asynchronous active-low reset
// - snap_regs       in   DATA_WIDTH x NUM_REGS snapshot contents; stable while busy
// - snap_valid      in   1                     a snapshot is held
// - snapshot_taken  in   1                     1-cycle pulse: new snapshot captured; clears dirty mask
// - wb_we           in   1                     writeback commit strobe
// - wb_addr         in   AW                    writeback destination register
// - rollback        in   1                     1-cycle pulse: mispredict, start restore
// - rf_we           out  1                     register file write enable
// - rf_waddr        out  AW                    register file write address
// - rf_wdata        out  DATA_WIDTH            register file write data
// - busy            out  1                     restore in progress; stall pipeline
// - done            out  1                     1-cycle pulse: restore complete
// BEHAVIOUR
// - Reset (async): state IDLE, dirty = 0, outputs rf_we/rf_waddr/rf_wdata/busy/done = 0.
// - Dirty tracking, IDLE only:
//   - wb_we && wb_addr != 0 sets dirty[wb_addr]; register 0 is never dirty.
//   - snapshot_taken clears dirty; a wb_we in the same cycle counts as post-snapshot, so its bit is set.
//   - wb_we and snapshot_taken are ignored while busy.
// - FSM states IDLE, RESTORE, FINISH:
//   - IDLE -> RESTORE on rollback && snap_valid && dirty != 0.
//   - IDLE -> FINISH on rollback && snap_valid && dirty == 0.
//   - rollback with snap_valid = 0 is ignored: no busy, no done.
//   - RESTORE:
//     - Each cycle: i = lowest set dirty index; rf_we = 1, rf_waddr = i, rf_wdata = snap_regs[i]; dirty[i] cleared at that edge.
//     - -> FINISH after the cycle that writes the last dirty bit.
//   - FINISH: done = 1 for exactly one cycle, rf_we = 0; -> IDLE.
// - busy = 1 in RESTORE and FINISH. All outputs are registered (decoded from state/regs).
// - rollback while busy is ignored.
// - Latency (rollback sampled at edge k, n dirty registers):
//   - writes occupy cycles k+1..k+n in ascending index order;
//   - done at k+n+1; idle at k+n+2;
//   - n = 0 gives done at k+1.
// - Maximum n = NUM_REGS-1.
// - Reset mid-restore: immediate return to IDLE, all outputs 0, dirty cleared; the partial restore is abandoned, not resumed.
// TESTING
// - Reset: rst_n=0 with rollback=1 -> rf_we, busy, done all 0; after release, rollback with no writes -> no rf_we.
// - snapshot_taken; wb writes r3, r17, r3; snap_regs[3]=0xAAAA0003, snap_regs[17]=0x11110017; rollback at k -> k+1: we,3,0xAAAA0003; k+2: we,17,0x11110017; k+3: done=1; busy high k+1..k+3.
// - snapshot_taken, no writes, rollback at k -> busy and done at k+1, rf_we never asserted.
// - wb_we to r0 only, then rollback -> no rf_we, done at k+1.
// - snapshot_taken and wb_we r5 in the same cycle, then rollback -> r5 restored (rf_waddr=5 at k+1).
// - Mid-restore reset: dirty {r2, r9}; pull rst_n low after the r2 write -> outputs 0 immediately; after release, rollback -> no rf_we, done at k+1.
// - rollback with snap_valid=0 -> busy/done stay 0; second rollback while busy (cycle k+1) -> latency unchanged, single done pulse.

Source files
------------

// File: rtl/register_restore_if.sv
// Bundle between the restore engine, the hazard/snapshot side and the register file
// write port. Everything except clock and reset travels through here.
interface register_restore_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
);
   localparam int AW = $clog2(NUM_REGS);

   // Protocol: snapshot_taken and rollback are single-cycle pulses sampled on the
   // rising edge; wb_we qualifies wb_addr in the same cycle. snap_regs must be held
   // stable while busy. On the write side, rf_we qualifies rf_waddr/rf_wdata each
   // cycle with no back-pressure, busy stalls the producer, and done pulses once
   // per accepted rollback.
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] snap_regs;
   logic                                snap_valid;
   logic                                snapshot_taken;
   logic                                wb_we;
   logic [AW-1:0]                       wb_addr;
   logic                                rollback;
   logic                                rf_we;
   logic [AW-1:0]                       rf_waddr;
   logic [DATA_WIDTH-1:0]               rf_wdata;
   logic                                busy;
   logic                                done;

   modport slave (
      input  snap_regs, snap_valid, snapshot_taken, wb_we, wb_addr, rollback,
      output rf_we, rf_waddr, rf_wdata, busy, done
   );

   modport master (
      output snap_regs, snap_valid, snapshot_taken, wb_we, wb_addr, rollback,
      input  rf_we, rf_waddr, rf_wdata, busy, done
   );
endinterface

// File: rtl/register_restore.sv
// Speculation rollback engine: tracks registers written since the last snapshot and,
// on a mispredict, writes their snapshot values back one per cycle, lowest index first.
module register_restore #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   register_restore_if.slave rr,
   output logic [1:0]        o_dbg_state
);
   localparam int AW = $clog2(NUM_REGS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RESTORE = 2'd1,
      S_FINISH  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [NUM_REGS-1:0]   r_dirty;
   logic [NUM_REGS-1:0]   w_dirty_nxt;
   logic [NUM_REGS-1:0]   w_clr_mask;
   logic [NUM_REGS-1:0]   w_scan;
   logic [AW-1:0]         w_low_idx;
   logic                  w_low_any;
   logic                  r_rf_we;
   logic                  w_rf_we_nxt;
   logic [AW-1:0]         r_rf_waddr;
   logic [AW-1:0]         w_rf_waddr_nxt;
   logic [DATA_WIDTH-1:0] r_rf_wdata;
   logic [DATA_WIDTH-1:0] w_rf_wdata_nxt;
   logic                  r_busy;
   logic                  r_done;

   // The register being written this cycle leaves the pending set at the coming edge,
   // so the next write is picked from what remains.
   always_comb begin
      w_clr_mask = '0;
      if (r_state == S_RESTORE) begin
         w_clr_mask[r_rf_waddr] = 1'b1;
      end
   end

   assign w_scan = r_dirty & ~w_clr_mask;

   always_comb begin : lowest_pick
      w_low_idx = '0;
      w_low_any = 1'b0;
      for (int i = NUM_REGS - 1; i >= 0; i--) begin
         if (w_scan[i]) begin
            w_low_idx = AW'(i);
            w_low_any = 1'b1;
         end
      end
   end

   always_comb begin : next_state
      w_state_nxt    = r_state;
      w_dirty_nxt    = r_dirty;
      w_rf_we_nxt    = 1'b0;
      w_rf_waddr_nxt = '0;
      w_rf_wdata_nxt = '0;

      case (r_state)
         S_IDLE: begin
            // A writeback alongside snapshot_taken is newer than the snapshot.
            if (rr.snapshot_taken) begin
               w_dirty_nxt = '0;
            end
            if (rr.wb_we && (rr.wb_addr != '0)) begin
               w_dirty_nxt[rr.wb_addr] = 1'b1;
            end
            if (rr.rollback && rr.snap_valid) begin
               w_state_nxt = w_low_any ? S_RESTORE : S_FINISH;
            end
         end
         S_RESTORE: begin
            w_dirty_nxt = w_scan;
            w_state_nxt = w_low_any ? S_RESTORE : S_FINISH;
         end
         S_FINISH: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (w_state_nxt == S_RESTORE) begin
         w_rf_we_nxt    = 1'b1;
         w_rf_waddr_nxt = w_low_idx;
         w_rf_wdata_nxt = rr.snap_regs[w_low_idx];
      end
   end

   // Outputs are registered one step ahead of the state they describe, so a reset
   // mid-restore silences the write port on the same edge it aborts the sequence.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_dirty    <= '0;
         r_rf_we    <= 1'b0;
         r_rf_waddr <= '0;
         r_rf_wdata <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_dirty    <= w_dirty_nxt;
         r_rf_we    <= w_rf_we_nxt;
         r_rf_waddr <= w_rf_waddr_nxt;
         r_rf_wdata <= w_rf_wdata_nxt;
         r_busy     <= (w_state_nxt != S_IDLE);
         r_done     <= (w_state_nxt == S_FINISH);
      end
   end

   assign rr.rf_we     = r_rf_we;
   assign rr.rf_waddr  = r_rf_waddr;
   assign rr.rf_wdata  = r_rf_wdata;
   assign rr.busy      = r_busy;
   assign rr.done      = r_done;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_register_restore.sv
// Bench for register_restore: a dirty-mask model predicts the restore writes into a
// queue, a monitor pops them as rf_we fires, and each rollback is checked cycle by cycle.
module tb_register_restore;
   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = $clog2(NR);
   localparam int EW = AW + DW;

   logic          clk;
   logic          rst_n;
   logic [1:0]    dbg_state;
   logic [NR-1:0] model_dirty;
   logic [EW-1:0] exp_q[$];
   int            n_vec;
   int            n_bad;

   register_restore_if #(.DATA_WIDTH(DW), .NUM_REGS(NR)) rr ();

   register_restore #(.DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rr          (rr.slave),
      .o_dbg_state (dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // scoreboard monitor: every register-file write must match the head of exp_q
   always @(negedge clk) begin
      if (rr.rf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_extra", 64'({rr.rf_waddr, rr.rf_wdata}), 64'(0));
         end else begin
            logic [EW-1:0] e;
            e = exp_q.pop_front();
            check("wr", 64'({rr.rf_waddr, rr.rf_wdata}), 64'(e));
         end
      end
   end

   // drivers: all start and end 1 time unit after a rising edge
   task automatic take_snapshot();
      rr.snapshot_taken = 1'b1;
      @(posedge clk); #1;
      rr.snapshot_taken = 1'b0;
      model_dirty = '0;
   endtask

   task automatic wb_write(input int addr, input bit with_snap);
      rr.wb_we          = 1'b1;
      rr.wb_addr        = AW'(addr);
      rr.snapshot_taken = with_snap;
      @(posedge clk); #1;
      rr.wb_we          = 1'b0;
      rr.snapshot_taken = 1'b0;
      if (with_snap) model_dirty = '0;
      if (addr != 0) model_dirty[addr] = 1'b1;
   endtask

   task automatic randomize_snap();
      for (int i = 0; i < NR; i++) rr.snap_regs[i] = $urandom;
   endtask

   // Rollback sampled at edge k; checks cycles k+1 .. k+n+2. hold_two keeps rollback
   // high through edge k+1; poke_wb drives writebacks/snapshots while busy.
   task automatic do_rollback(input string tag, input bit hold_two, input bit poke_wb);
      int n;
      bit acc;
      n   = 0;
      acc = rr.snap_valid;
      if (acc) begin
         for (int i = 0; i < NR; i++) begin
            if (model_dirty[i]) begin
               exp_q.push_back({AW'(i), rr.snap_regs[i]});
               n++;
            end
         end
      end
      rr.rollback = 1'b1;
      @(posedge clk); #1;
      if (!hold_two) rr.rollback = 1'b0;
      if (acc && poke_wb) begin
         rr.wb_we          = 1'b1;
         rr.wb_addr        = AW'(11);
         rr.snapshot_taken = 1'b1;
      end
      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk);
         if (!acc) begin
            check({tag, "_busy"}, 64'(rr.busy), 64'(0));
            check({tag, "_done"}, 64'(rr.done), 64'(0));
            check({tag, "_we"},   64'(rr.rf_we), 64'(0));
         end else if (c <= n) begin
            check({tag, "_busy"}, 64'(rr.busy), 64'(1));
            check({tag, "_we"},   64'(rr.rf_we), 64'(1));
            check({tag, "_done"}, 64'(rr.done), 64'(0));
         end else if (c == n + 1) begin
            check({tag, "_busy"}, 64'(rr.busy), 64'(1));
            check({tag, "_done"}, 64'(rr.done), 64'(1));
            check({tag, "_we"},   64'(rr.rf_we), 64'(0));
         end else begin
            check({tag, "_busy"}, 64'(rr.busy), 64'(0));
            check({tag, "_done"}, 64'(rr.done), 64'(0));
            check({tag, "_we"},   64'(rr.rf_we), 64'(0));
         end
         @(posedge clk); #1;
         rr.rollback = 1'b0;
         if (c == n + 1) begin
            rr.wb_we          = 1'b0;
            rr.snapshot_taken = 1'b0;
         end
      end
      check({tag, "_drain"}, 64'(exp_q.size()), 64'(0));
      if (acc) model_dirty = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_vec = 0;
      n_bad = 0;
      model_dirty       = '0;
      rst_n             = 1'b0;
      rr.snap_valid     = 1'b1;
      rr.snapshot_taken = 1'b0;
      rr.wb_we          = 1'b0;
      rr.wb_addr        = '0;
      rr.rollback       = 1'b1;
      randomize_snap();

      // reset holds everything quiet even with rollback asserted
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_we",    64'(rr.rf_we),    64'(0));
      check("rst_busy",  64'(rr.busy),     64'(0));
      check("rst_done",  64'(rr.done),     64'(0));
      check("rst_addr",  64'(rr.rf_waddr), 64'(0));
      check("rst_data",  64'(rr.rf_wdata), 64'(0));
      check("rst_state", 64'(dbg_state),   64'(0));
      @(posedge clk); #1;
      rr.rollback = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_rollback("rst_idle", 1'b0, 1'b0);

      // two dirty registers, one written twice
      take_snapshot();
      wb_write(3, 1'b0);
      wb_write(17, 1'b0);
      wb_write(3, 1'b0);
      rr.snap_regs[3]  = 32'hAAAA0003;
      rr.snap_regs[17] = 32'h11110017;
      do_rollback("two", 1'b0, 1'b0);

      take_snapshot();
      do_rollback("none", 1'b0, 1'b0);

      take_snapshot();
      wb_write(0, 1'b0);
      do_rollback("r0", 1'b0, 1'b0);

      // writeback in the snapshot cycle is post-snapshot
      take_snapshot();
      wb_write(5, 1'b1);
      do_rollback("same", 1'b0, 1'b0);

      // reset after the r2 write abandons the r9 write
      take_snapshot();
      wb_write(9, 1'b0);
      wb_write(2, 1'b0);
      exp_q.push_back({AW'(2), rr.snap_regs[2]});
      rr.rollback = 1'b1;
      @(posedge clk); #1;
      rr.rollback = 1'b0;
      @(negedge clk);
      check("mid_we1", 64'(rr.rf_we), 64'(1));
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("mid_we",    64'(rr.rf_we),    64'(0));
      check("mid_busy",  64'(rr.busy),     64'(0));
      check("mid_done",  64'(rr.done),     64'(0));
      check("mid_addr",  64'(rr.rf_waddr), 64'(0));
      check("mid_state", 64'(dbg_state),   64'(0));
      check("mid_drain", 64'(exp_q.size()), 64'(0));
      model_dirty = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_rollback("post_rst", 1'b0, 1'b0);

      // rollback without a snapshot is ignored; the dirty bit survives it
      wb_write(7, 1'b0);
      rr.snap_valid = 1'b0;
      do_rollback("noval", 1'b0, 1'b0);
      rr.snap_valid = 1'b1;
      wb_write(20, 1'b0);
      do_rollback("busy_rb", 1'b1, 1'b1);
      do_rollback("after_busy", 1'b0, 1'b0);

      // maximum restore: every register except r0
      randomize_snap();
      take_snapshot();
      for (int a = 1; a < NR; a++) wb_write(a, 1'b0);
      do_rollback("max", 1'b0, 1'b0);

      for (int r = 0; r < 6; r++) begin
         int cnt;
         if ($urandom_range(0, 1) == 1) take_snapshot();
         cnt = $urandom_range(0, 6);
         for (int w = 0; w < cnt; w++) begin
            wb_write($urandom_range(0, NR - 1), ($urandom_range(0, 3) == 0));
         end
         randomize_snap();
         do_rollback("rnd", $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
